// File: rtl/alu_pkg.sv
// Shared ALU op codes, operand-select constants and the ID/EX payload record.
package alu_pkg;

  localparam int unsigned XLEN     = 32;
  localparam int unsigned REG_W    = 5;
  localparam int unsigned ALU_OP_W = 6;

  typedef enum logic [ALU_OP_W-1:0] {
    OP_ALU_PC = 6'd0,
    OP_ADD    = 6'd1,
    OP_SUB    = 6'd2,
    OP_AND    = 6'd3,
    OP_OR     = 6'd4,
    OP_XOR    = 6'd5,
    OP_SLTU   = 6'd7,
    OP_SLT    = 6'd8,
    OP_SLL    = 6'd9,
    OP_SRL    = 6'd10,
    OP_SRA    = 6'd11,
    OP_EQ     = 6'd12,
    OP_NEQ    = 6'd13
  } alu_op_t;

  localparam logic SRC_A_RS1 = 1'b0;
  localparam logic SRC_A_PC  = 1'b1;
  localparam logic SRC_B_RS2 = 1'b0;
  localparam logic SRC_B_IMM = 1'b1;

  typedef struct packed {
    logic [XLEN-1:0]  pc;
    logic [XLEN-1:0]  rs1_data;
    logic [XLEN-1:0]  rs2_data;
    logic [XLEN-1:0]  imm;
    logic [REG_W-1:0] rs1_addr;
    logic [REG_W-1:0] rs2_addr;
    logic [REG_W-1:0] rd_addr;
    logic             rd_we;
    alu_op_t          alu_op;
    logic             src_a_sel;
    logic             src_b_sel;
  } id_ex_payload_t;

endpackage

// File: rtl/fwd_mux.sv
// Priority forwarding select for one source operand (EX/MEM over MEM/WB over regfile).
// Forwarding network is built only when ID_EX_FWD_EN is defined.
module fwd_mux #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned REG_ADDR_W = 5
) (
  input  logic [REG_ADDR_W-1:0] i_rs_addr,
  input  logic [WIDTH-1:0]      i_rs_data,
  input  logic [REG_ADDR_W-1:0] i_exmem_rd_addr,
  input  logic                  i_exmem_rd_we,
  input  logic [WIDTH-1:0]      i_exmem_result,
  input  logic [REG_ADDR_W-1:0] i_memwb_rd_addr,
  input  logic                  i_memwb_rd_we,
  input  logic [WIDTH-1:0]      i_memwb_result,
  output logic [WIDTH-1:0]      o_data
);

`ifdef ID_EX_FWD_EN
  logic w_rs_nz;
  logic w_hit_exmem;
  logic w_hit_memwb;

  // x0 is hardwired zero, so a producer targeting it must never be forwarded
  assign w_rs_nz     = (i_rs_addr != '0);
  assign w_hit_exmem = w_rs_nz & i_exmem_rd_we & (i_exmem_rd_addr == i_rs_addr);
  assign w_hit_memwb = w_rs_nz & i_memwb_rd_we & (i_memwb_rd_addr == i_rs_addr);

  always_comb begin
    o_data = i_rs_data;
    if (w_hit_exmem)      o_data = i_exmem_result;
    else if (w_hit_memwb) o_data = i_memwb_result;
  end
`else
  logic w_unused_fwd;

  assign w_unused_fwd = ^{i_rs_addr, i_exmem_rd_addr, i_exmem_rd_we, i_exmem_result,
                          i_memwb_rd_addr, i_memwb_rd_we, i_memwb_result};
  assign o_data       = i_rs_data;
`endif

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with valid/ready handshake, flush and operand forwarding.
// Define ID_EX_FWD_EN to build the EX/MEM and MEM/WB forwarding network.
module id_ex_stage #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned REG_ADDR_W = 5
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic [WIDTH-1:0]      i_pc,
  input  logic [WIDTH-1:0]      i_rs1_data,
  input  logic [WIDTH-1:0]      i_rs2_data,
  input  logic [WIDTH-1:0]      i_imm,
  input  logic [REG_ADDR_W-1:0] i_rs1_addr,
  input  logic [REG_ADDR_W-1:0] i_rs2_addr,
  input  logic [REG_ADDR_W-1:0] i_rd_addr,
  input  logic                  i_rd_we,
  input  logic [5:0]            i_alu_op,
  input  logic                  i_src_a_sel,
  input  logic                  i_src_b_sel,
  input  logic                  i_flush,
  input  logic [REG_ADDR_W-1:0] i_exmem_rd_addr,
  input  logic                  i_exmem_rd_we,
  input  logic [WIDTH-1:0]      i_exmem_result,
  input  logic [REG_ADDR_W-1:0] i_memwb_rd_addr,
  input  logic                  i_memwb_rd_we,
  input  logic [WIDTH-1:0]      i_memwb_result,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [5:0]            o_alu_op,
  output logic [WIDTH-1:0]      o_alu_a,
  output logic [WIDTH-1:0]      o_alu_b,
  output logic [WIDTH-1:0]      o_store_data,
  output logic [WIDTH-1:0]      o_pc,
  output logic [REG_ADDR_W-1:0] o_rd_addr,
  output logic                  o_rd_we
);

  import alu_pkg::*;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

  state_t         r_state;
  state_t         w_state_nxt;
  id_ex_payload_t r_pl;
  id_ex_payload_t w_pl_in;
  logic           w_valid;
  logic           w_load;
  logic [WIDTH-1:0] w_fwd_rs1;
  logic [WIDTH-1:0] w_fwd_rs2;

  assign w_valid = (r_state == ST_FULL);
  assign o_ready = ~w_valid | i_ready | i_flush;
  assign w_load  = i_valid & o_ready & ~i_flush;

  assign w_pl_in = '{
    pc:        i_pc,
    rs1_data:  i_rs1_data,
    rs2_data:  i_rs2_data,
    imm:       i_imm,
    rs1_addr:  i_rs1_addr,
    rs2_addr:  i_rs2_addr,
    rd_addr:   i_rd_addr,
    rd_we:     i_rd_we,
    alu_op:    alu_op_t'(i_alu_op),
    src_a_sel: i_src_a_sel,
    src_b_sel: i_src_b_sel
  };

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= ST_EMPTY;
    else          r_state <= w_state_nxt;
  end

  // Flush wins over capture; a capture while draining keeps the stage full.
  always_comb begin
    w_state_nxt = r_state;
    if (i_flush)                  w_state_nxt = ST_EMPTY;
    else if (w_load)              w_state_nxt = ST_FULL;
    else if (w_valid && i_ready)  w_state_nxt = ST_EMPTY;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)    r_pl <= '0;
    else if (w_load) r_pl <= w_pl_in;
  end

  fwd_mux #(.WIDTH(WIDTH), .REG_ADDR_W(REG_ADDR_W)) u_fwd_rs1 (
    .i_rs_addr       (r_pl.rs1_addr),
    .i_rs_data       (r_pl.rs1_data),
    .i_exmem_rd_addr (i_exmem_rd_addr),
    .i_exmem_rd_we   (i_exmem_rd_we),
    .i_exmem_result  (i_exmem_result),
    .i_memwb_rd_addr (i_memwb_rd_addr),
    .i_memwb_rd_we   (i_memwb_rd_we),
    .i_memwb_result  (i_memwb_result),
    .o_data          (w_fwd_rs1)
  );

  fwd_mux #(.WIDTH(WIDTH), .REG_ADDR_W(REG_ADDR_W)) u_fwd_rs2 (
    .i_rs_addr       (r_pl.rs2_addr),
    .i_rs_data       (r_pl.rs2_data),
    .i_exmem_rd_addr (i_exmem_rd_addr),
    .i_exmem_rd_we   (i_exmem_rd_we),
    .i_exmem_result  (i_exmem_result),
    .i_memwb_rd_addr (i_memwb_rd_addr),
    .i_memwb_rd_we   (i_memwb_rd_we),
    .i_memwb_result  (i_memwb_result),
    .o_data          (w_fwd_rs2)
  );

  assign o_valid      = w_valid;
  assign o_alu_op     = r_pl.alu_op;
  assign o_alu_a      = (r_pl.src_a_sel == SRC_A_PC)  ? r_pl.pc  : w_fwd_rs1;
  assign o_alu_b      = (r_pl.src_b_sel == SRC_B_IMM) ? r_pl.imm : w_fwd_rs2;
  assign o_store_data = w_fwd_rs2;
  assign o_pc         = r_pl.pc;
  assign o_rd_addr    = r_pl.rd_addr;
  assign o_rd_we      = w_valid & r_pl.rd_we;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed scenarios plus randomized traffic
// checked against a behavioural model of the stage.
module tb_id_ex_stage;

  logic        clk;
  logic        rst_n;
  logic        i_valid, o_ready;
  logic [31:0] i_pc, i_rs1_data, i_rs2_data, i_imm;
  logic [4:0]  i_rs1_addr, i_rs2_addr, i_rd_addr;
  logic        i_rd_we;
  logic [5:0]  i_alu_op;
  logic        i_src_a_sel, i_src_b_sel, i_flush;
  logic [4:0]  i_exmem_rd_addr, i_memwb_rd_addr;
  logic        i_exmem_rd_we, i_memwb_rd_we;
  logic [31:0] i_exmem_result, i_memwb_result;
  logic        o_valid, i_ready;
  logic [5:0]  o_alu_op;
  logic [31:0] o_alu_a, o_alu_b, o_store_data, o_pc;
  logic [4:0]  o_rd_addr;
  logic        o_rd_we;

  int unsigned n_chk  = 0;
  int unsigned n_pass = 0;

  typedef struct {
    logic [31:0] pc, rs1d, rs2d, imm;
    logic [4:0]  rs1a, rs2a, rd;
    logic        we;
    logic [5:0]  op;
    logic        sa, sb;
  } instr_t;

  bit     m_valid;
  instr_t m_ins;

  id_ex_stage #(.WIDTH(32), .REG_ADDR_W(5)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(i_valid), .o_ready(o_ready),
    .i_pc(i_pc), .i_rs1_data(i_rs1_data), .i_rs2_data(i_rs2_data), .i_imm(i_imm),
    .i_rs1_addr(i_rs1_addr), .i_rs2_addr(i_rs2_addr), .i_rd_addr(i_rd_addr),
    .i_rd_we(i_rd_we), .i_alu_op(i_alu_op), .i_src_a_sel(i_src_a_sel),
    .i_src_b_sel(i_src_b_sel), .i_flush(i_flush),
    .i_exmem_rd_addr(i_exmem_rd_addr), .i_exmem_rd_we(i_exmem_rd_we),
    .i_exmem_result(i_exmem_result), .i_memwb_rd_addr(i_memwb_rd_addr),
    .i_memwb_rd_we(i_memwb_rd_we), .i_memwb_result(i_memwb_result),
    .o_valid(o_valid), .i_ready(i_ready), .o_alu_op(o_alu_op),
    .o_alu_a(o_alu_a), .o_alu_b(o_alu_b), .o_store_data(o_store_data),
    .o_pc(o_pc), .o_rd_addr(o_rd_addr), .o_rd_we(o_rd_we)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Value the ALU should see for a source register given the live bypass inputs.
  function automatic logic [31:0] src_val(input logic [4:0] a, input logic [31:0] d);
`ifdef ID_EX_FWD_EN
    if (a != 0 && i_exmem_rd_we && i_exmem_rd_addr == a) return i_exmem_result;
    if (a != 0 && i_memwb_rd_we && i_memwb_rd_addr == a) return i_memwb_result;
`endif
    return d;
  endfunction

  task automatic check_model();
    logic [31:0] r1, r2;
    chk("ready", o_ready, (!m_valid || i_ready || i_flush));
    chk("valid", o_valid, m_valid);
    chk("rd_we", o_rd_we, m_valid && m_ins.we);
    if (m_valid) begin
      r1 = src_val(m_ins.rs1a, m_ins.rs1d);
      r2 = src_val(m_ins.rs2a, m_ins.rs2d);
      chk("alu_op", o_alu_op, m_ins.op);
      chk("alu_a", o_alu_a, m_ins.sa ? m_ins.pc : r1);
      chk("alu_b", o_alu_b, m_ins.sb ? m_ins.imm : r2);
      chk("store", o_store_data, r2);
      chk("pc", o_pc, m_ins.pc);
      chk("rd_addr", o_rd_addr, m_ins.rd);
    end
  endtask

  task automatic model_edge();
    bit acc;
    acc = !m_valid || i_ready || i_flush;
    if (i_flush) m_valid = 1'b0;
    else if (i_valid && acc) begin
      m_valid = 1'b1;
      m_ins = '{pc: i_pc, rs1d: i_rs1_data, rs2d: i_rs2_data, imm: i_imm,
                rs1a: i_rs1_addr, rs2a: i_rs2_addr, rd: i_rd_addr, we: i_rd_we,
                op: i_alu_op, sa: i_src_a_sel, sb: i_src_b_sel};
    end else if (m_valid && i_ready) m_valid = 1'b0;
  endtask

  // Called at posedge+1 with inputs set; checks, crosses one edge, returns at posedge+1.
  task automatic step();
    #1 check_model();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic set_instr(input logic [31:0] pc, input logic [4:0] r1a, input logic [4:0] r2a,
                           input logic [31:0] r1d, input logic [31:0] r2d, input logic [31:0] imm,
                           input logic [4:0] rd, input logic [5:0] op, input logic sa, input logic sb);
    i_valid = 1'b1; i_pc = pc; i_rs1_addr = r1a; i_rs2_addr = r2a;
    i_rs1_data = r1d; i_rs2_data = r2d; i_imm = imm; i_rd_addr = rd; i_rd_we = 1'b1;
    i_alu_op = op; i_src_a_sel = sa; i_src_b_sel = sb;
  endtask

  task automatic clr_fwd();
    i_exmem_rd_addr = '0; i_exmem_rd_we = 1'b0; i_exmem_result = '0;
    i_memwb_rd_addr = '0; i_memwb_rd_we = 1'b0; i_memwb_result = '0;
  endtask

  initial begin
    rst_n = 1'b0; i_flush = 1'b0; i_ready = 1'b1;
    set_instr(32'h0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 5'd0, 6'd0, 1'b0, 1'b0);
    i_valid = 1'b0; i_rd_we = 1'b0;
    clr_fwd();
    m_valid = 1'b0;
    m_ins = '{default: '0};
    #1;
    chk("rst_valid", o_valid, 1'b0);
    chk("rst_op", o_alu_op, 6'd0);
    chk("rst_rd_we", o_rd_we, 1'b0);
    chk("rst_pc", o_pc, 32'h0);
    chk("rst_rd_addr", o_rd_addr, 5'd0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;

    // ADD with no bypass
    set_instr(32'h10, 5'd3, 5'd4, 32'd5, 32'd7, 32'h0, 5'd5, 6'd1, 1'b0, 1'b0);
    step();
    i_valid = 1'b0;
    chk("add_valid", o_valid, 1'b1);
    chk("add_a", o_alu_a, 32'd5);
    chk("add_b", o_alu_b, 32'd7);
    chk("add_op", o_alu_op, 6'd1);

    // Hold it and vary the bypass inputs
    i_ready = 1'b0;
    i_exmem_rd_addr = 5'd3; i_exmem_rd_we = 1'b1; i_exmem_result = 32'h100;
    i_memwb_rd_addr = 5'd3; i_memwb_rd_we = 1'b1; i_memwb_result = 32'h200;
    #1;
`ifdef ID_EX_FWD_EN
    chk("fwd_exmem_prio", o_alu_a, 32'h100);
`else
    chk("fwd_off_a", o_alu_a, 32'd5);
`endif
    step();
    i_exmem_rd_we = 1'b0;
    #1;
`ifdef ID_EX_FWD_EN
    chk("fwd_memwb", o_alu_a, 32'h200);
`else
    chk("fwd_off_a2", o_alu_a, 32'd5);
`endif
    step();

    // x0 must never be forwarded
    i_ready = 1'b1;
    clr_fwd();
    set_instr(32'h14, 5'd0, 5'd0, 32'd9, 32'd11, 32'h0, 5'd6, 6'd2, 1'b0, 1'b0);
    step();
    i_valid = 1'b0; i_ready = 1'b0;
    i_exmem_rd_addr = 5'd0; i_exmem_rd_we = 1'b1; i_exmem_result = 32'hDEAD;
    #1;
    chk("x0_a", o_alu_a, 32'd9);
    chk("x0_store", o_store_data, 32'd11);
    clr_fwd();

    // Back-pressure: offered beat waits until downstream frees up
    set_instr(32'h18, 5'd1, 5'd2, 32'hA, 32'hB, 32'h0, 5'd7, 6'd3, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_ready", o_ready, 1'b0);
      chk("stall_pc", o_pc, 32'h14);
    end
    i_ready = 1'b1;
    step();
    i_valid = 1'b0;
    chk("release_pc", o_pc, 32'h18);

    // Flush squashes held and incoming beats
    i_ready = 1'b0; i_flush = 1'b1;
    set_instr(32'h1C, 5'd1, 5'd2, 32'h1, 32'h2, 32'h0, 5'd8, 6'd4, 1'b0, 1'b0);
    #1 chk("flush_ready", o_ready, 1'b1);
    step();
    i_flush = 1'b0; i_valid = 1'b0;
    chk("flush_valid", o_valid, 1'b0);
    chk("flush_rd_we", o_rd_we, 1'b0);

    // PC/immediate operands, then reset while stalled
    i_ready = 1'b1;
    set_instr(32'h80, 5'd1, 5'd2, 32'h1, 32'h2, 32'd4, 5'd9, 6'd0, 1'b1, 1'b1);
    step();
    i_valid = 1'b0; i_ready = 1'b0;
    chk("pc_a", o_alu_a, 32'h80);
    chk("imm_b", o_alu_b, 32'd4);
    step();
    rst_n = 1'b0;
    #1 chk("rst_mid_valid", o_valid, 1'b0);
    chk("rst_mid_rd_we", o_rd_we, 1'b0);
    m_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Randomized traffic with a narrow register range to provoke hazards
    for (int n = 0; n < 400; n++) begin
      i_valid         = 1'($urandom_range(0, 1));
      i_ready         = ($urandom_range(0, 3) != 0);
      i_flush         = ($urandom_range(0, 9) == 0);
      i_pc            = $urandom; i_imm = $urandom;
      i_rs1_data      = $urandom; i_rs2_data = $urandom;
      i_rs1_addr      = 5'($urandom_range(0, 3));
      i_rs2_addr      = 5'($urandom_range(0, 3));
      i_rd_addr       = 5'($urandom_range(0, 31));
      i_rd_we         = 1'($urandom_range(0, 1));
      i_alu_op        = 6'($urandom_range(0, 63));
      i_src_a_sel     = 1'($urandom_range(0, 1));
      i_src_b_sel     = 1'($urandom_range(0, 1));
      i_exmem_rd_addr = 5'($urandom_range(0, 3));
      i_exmem_rd_we   = 1'($urandom_range(0, 1));
      i_exmem_result  = $urandom;
      i_memwb_rd_addr = 5'($urandom_range(0, 3));
      i_memwb_rd_we   = 1'($urandom_range(0, 1));
      i_memwb_result  = $urandom;
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
